// File: rtl/matrix_load_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_load_sequencer
//  Description : Streams NUM_MATRIX matrices from an async-read source memory
//                into `top` using the start_in / valid_input / X_load protocol.
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_load_sequencer #(
    parameter int NUM_MATRIX       = 2,
    parameter int WORDS_PER_MATRIX = 32,
    parameter int GAP_CYCLES       = 3,
    localparam int ADDR_W          = $clog2(NUM_MATRIX * WORDS_PER_MATRIX),
    localparam int MI_W            = $clog2(NUM_MATRIX) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              stop,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [7:0]        src_data,
    output logic              start_in,
    output logic              valid_input,
    output logic [7:0]        X_load,
    input  logic              finish,
    output logic [MI_W-1:0]   mat_idx,
    output logic              busy,
    output logic              done
);

    localparam int WC_W = $clog2(WORDS_PER_MATRIX);
    localparam int GC_W = $clog2(GAP_CYCLES) + 1;

    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WORDS_PER_MATRIX - 1);
    localparam logic [MI_W-1:0] MI_LAST = MI_W'(NUM_MATRIX - 1);
    localparam logic [GC_W-1:0] GC_LAST = GC_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        LOAD     = 3'd2,
        WAIT_FIN = 3'd3,
        GAP      = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WC_W-1:0] word_cnt;
    logic [WC_W-1:0] word_cnt_nxt;
    logic [MI_W-1:0] mat_idx_nxt;
    logic [GC_W-1:0] gap_cnt;
    logic [GC_W-1:0] gap_cnt_nxt;

    logic              in_load;
    logic [ADDR_W-1:0] base_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            word_cnt <= '0;
            mat_idx  <= '0;
            gap_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            word_cnt <= word_cnt_nxt;
            mat_idx  <= mat_idx_nxt;
            gap_cnt  <= gap_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        word_cnt_nxt = word_cnt;
        mat_idx_nxt  = mat_idx;
        gap_cnt_nxt  = gap_cnt;

        // Abort wins over everything, including a go seen in IDLE.
        if (stop) begin
            state_nxt    = IDLE;
            word_cnt_nxt = '0;
            mat_idx_nxt  = '0;
            gap_cnt_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        state_nxt   = START;
                        mat_idx_nxt = '0;
                    end
                end
                START: begin
                    state_nxt    = LOAD;
                    word_cnt_nxt = '0;
                end
                LOAD: begin
                    word_cnt_nxt = word_cnt + 1'b1;
                    if (word_cnt == WC_LAST) begin
                        state_nxt = WAIT_FIN;
                    end
                end
                WAIT_FIN: begin
                    if (finish) begin
                        if (mat_idx == MI_LAST) begin
                            state_nxt = DONE;
                        end else begin
                            state_nxt   = GAP;
                            mat_idx_nxt = mat_idx + 1'b1;
                            gap_cnt_nxt = '0;
                        end
                    end
                end
                GAP: begin
                    gap_cnt_nxt = gap_cnt + 1'b1;
                    if (gap_cnt == GC_LAST) begin
                        state_nxt = START;
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Matrix base is mat_idx * WORDS_PER_MATRIX; WORDS_PER_MATRIX is a power of two.
    assign in_load   = (state == LOAD);
    assign base_addr = ADDR_W'({mat_idx, {WC_W{1'b0}}});

    always_comb begin
        src_addr    = base_addr;
        X_load      = 8'h00;
        valid_input = 1'b0;
        if (in_load) begin
            src_addr    = base_addr + ADDR_W'(word_cnt);
            X_load      = src_data;
            valid_input = 1'b1;
        end
    end

    assign start_in = (state == START);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_matrix_load_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_load_sequencer
//  Description : Scoreboard bench for matrix_load_sequencer (2 x 32 words, gap 3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_load_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       go;
    logic       stop;
    logic       finish;
    logic [5:0] src_addr;
    logic [7:0] src_data;
    logic       start_in;
    logic       valid_input;
    logic [7:0] X_load;
    logic [1:0] mat_idx;
    logic       busy;
    logic       done;

    matrix_load_sequencer #(
        .NUM_MATRIX       (2),
        .WORDS_PER_MATRIX (32),
        .GAP_CYCLES       (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .stop        (stop),
        .src_addr    (src_addr),
        .src_data    (src_data),
        .start_in    (start_in),
        .valid_input (valid_input),
        .X_load      (X_load),
        .finish      (finish),
        .mat_idx     (mat_idx),
        .busy        (busy),
        .done        (done)
    );

    // Source memory holds word value == address (0x00..0x3F).
    assign src_data = {2'b00, src_addr};

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         runs_q[$];
    int         start_q[$];
    int         done_q[$];
    int         run_len = 0;
    int         idle_x_bad = 0;
    int         busy_last = 0;
    logic       vh[int];
    logic [1:0] mh[int];
    logic [5:0] ah[int];
    logic [7:0] e;
    logic [7:0] o;
    int         f_edge[2];
    int         go_edge;
    bit         tmo;
    bit         stopped;

    // Observation only: records what the DUT shows in each cycle.
    always @(negedge clk) begin
        vh[cyc] = valid_input;
        mh[cyc] = mat_idx;
        ah[cyc] = src_addr;
        if (valid_input) begin
            obs_q.push_back(X_load);
            run_len++;
        end else begin
            if (run_len != 0) begin
                runs_q.push_back(run_len);
                run_len = 0;
            end
            if (X_load !== 8'h00) idle_x_bad++;
        end
        if (start_in) start_q.push_back(cyc);
        if (done) done_q.push_back(cyc);
        if (busy) busy_last = cyc;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs;
        obs_q.delete(); exp_q.delete(); runs_q.delete();
        start_q.delete(); done_q.delete();
        vh.delete(); mh.delete(); ah.delete();
        run_len = 0; idle_x_bad = 0;
    endtask

    task automatic push_words(input int first, input int count);
        for (int i = 0; i < count; i++) exp_q.push_back(8'(first + i));
    endtask

    // Drives one job; finish follows WAIT_FIN entry by fin_delay cycles.
    task automatic run_job(input int fin_delay, input bit spurious, input bit repulse, input int stop_at);
        int n;
        int lc;
        bit seen;
        tmo = 0; stopped = 0;
        go = 1'b1;
        if (spurious) finish = 1'b1;
        tick;
        go = 1'b0;
        go_edge = cyc;
        for (int m = 0; m < 2; m++) begin
            n = 0; lc = 0; seen = 0;
            while (!(seen && !valid_input)) begin
                if (n >= 200) begin
                    tmo = 1; finish = 1'b0;
                    return;
                end
                if (valid_input) begin
                    seen = 1;
                    lc++;
                end
                go   = repulse && valid_input && (lc == 5);
                stop = (stop_at != 0) && (m == 1) && valid_input && (lc == stop_at);
                tick;
                n++;
                go = 1'b0;
                if (stop) begin
                    stop = 1'b0; stopped = 1;
                    return;
                end
            end
            if (spurious && m == 0) begin
                tick;
                f_edge[m] = cyc;
                finish = 1'b0;
            end else begin
                for (int i = 1; i < fin_delay; i++) begin
                    go = repulse && (i == 2);
                    tick;
                    go = 1'b0;
                end
                finish = 1'b1;
                tick;
                f_edge[m] = cyc;
                finish = 1'b0;
            end
        end
        repeat (3) tick;
    endtask

    task automatic test_reset;
        rst = 1'b0; go = 1'b0; stop = 1'b0; finish = 1'b0;
        #12;
        checks++; if (start_in !== 1'b0) begin errors++; $display("FAIL reset_start_in: got %0b expected 0", start_in); end
        checks++; if (valid_input !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", valid_input); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
        checks++; if (X_load !== 8'h00) begin errors++; $display("FAIL reset_x_load: got %0h expected 0", X_load); end
        checks++; if (src_addr !== 6'd0) begin errors++; $display("FAIL reset_src_addr: got %0d expected 0", src_addr); end
        checks++; if (mat_idx !== 2'd0) begin errors++; $display("FAIL reset_mat_idx: got %0d expected 0", mat_idx); end
        #6 rst = 1'b1;
        repeat (4) tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_hold: busy got %0b expected 0", busy); end
    endtask

    task automatic test_full_job;
        clear_obs;
        push_words(0, 64);
        run_job(5, 0, 0, 0);
        checks++; if (tmo) begin errors++; $display("FAIL full_timeout: got timeout expected completion"); end
        checks++; if (start_q.size() != 2) begin errors++; $display("FAIL full_starts: got %0d expected 2", start_q.size()); end
        checks++; if ((start_q.size() > 0 ? start_q[0] : -1) != go_edge) begin errors++; $display("FAIL full_start0_cycle: got %0d expected %0d", start_q.size() > 0 ? start_q[0] : -1, go_edge); end
        checks++; if ((start_q.size() > 1 ? start_q[1] : -1) != f_edge[0] + 3) begin errors++; $display("FAIL gap_start1_cycle: got %0d expected %0d", start_q.size() > 1 ? start_q[1] : -1, f_edge[0] + 3); end
        checks++; if (mh[f_edge[0] + 1] !== 2'd1) begin errors++; $display("FAIL gap_mat_idx: got %0d expected 1", mh[f_edge[0] + 1]); end
        checks++; if (ah[f_edge[0] + 1] !== 6'd32) begin errors++; $display("FAIL gap_src_addr: got %0d expected 32", ah[f_edge[0] + 1]); end
        checks++; if (vh[go_edge] !== 1'b0 || vh[go_edge + 1] !== 1'b1) begin errors++; $display("FAIL full_first_valid: got %0b%0b expected 01", vh[go_edge], vh[go_edge + 1]); end
        checks++; if (vh[go_edge + 32] !== 1'b1 || vh[go_edge + 33] !== 1'b0) begin errors++; $display("FAIL full_last_valid: got %0b%0b expected 10", vh[go_edge + 32], vh[go_edge + 33]); end
        checks++; if (runs_q.size() != 2 || runs_q[0] != 32 || runs_q[1] != 32) begin errors++; $display("FAIL full_runs: got %0d runs expected 2 runs of 32", runs_q.size()); end
        checks++; if (done_q.size() != 1 || done_q[0] != f_edge[1]) begin errors++; $display("FAIL full_done: got %0d pulses expected 1 at %0d", done_q.size(), f_edge[1]); end
        checks++; if (busy_last != f_edge[1]) begin errors++; $display("FAIL full_busy_fall: got last busy %0d expected %0d", busy_last, f_edge[1]); end
        checks++; if (idle_x_bad != 0) begin errors++; $display("FAIL full_idle_x_load: got %0d nonzero expected 0", idle_x_bad); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL full_word: got none expected %0h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL full_word: got %0h expected %0h", o, e); end end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL full_extra: got %0d extra expected 0", obs_q.size()); end
    endtask

    task automatic test_spurious_finish;
        clear_obs;
        push_words(0, 64);
        run_job(5, 1, 0, 0);
        checks++; if (tmo) begin errors++; $display("FAIL spur_timeout: got timeout expected completion"); end
        checks++; if (f_edge[0] != go_edge + 34) begin errors++; $display("FAIL spur_exit_edge: got %0d expected %0d", f_edge[0], go_edge + 34); end
        checks++; if ((start_q.size() > 1 ? start_q[1] : -1) != go_edge + 37) begin errors++; $display("FAIL spur_start1: got %0d expected %0d", start_q.size() > 1 ? start_q[1] : -1, go_edge + 37); end
        checks++; if (runs_q.size() != 2 || runs_q[0] != 32) begin errors++; $display("FAIL spur_runs: got %0d runs expected 2 of 32", runs_q.size()); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL spur_word: got none expected %0h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL spur_word: got %0h expected %0h", o, e); end end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL spur_extra: got %0d extra expected 0", obs_q.size()); end
    endtask

    task automatic test_go_repulse;
        clear_obs;
        push_words(0, 64);
        run_job(5, 0, 1, 0);
        checks++; if (tmo) begin errors++; $display("FAIL repulse_timeout: got timeout expected completion"); end
        checks++; if (start_q.size() != 2) begin errors++; $display("FAIL repulse_starts: got %0d expected 2", start_q.size()); end
        checks++; if (done_q.size() != 1) begin errors++; $display("FAIL repulse_done: got %0d expected 1", done_q.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL repulse_busy: got %0b expected 0", busy); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL repulse_word: got none expected %0h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL repulse_word: got %0h expected %0h", o, e); end end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL repulse_extra: got %0d extra expected 0", obs_q.size()); end
    endtask

    task automatic test_stop;
        clear_obs;
        push_words(0, 42);
        run_job(5, 0, 0, 10);
        checks++; if (!stopped) begin errors++; $display("FAIL stop_reached: got no stop expected stop at word 10"); end
        checks++; if (valid_input !== 1'b0) begin errors++; $display("FAIL stop_valid: got %0b expected 0", valid_input); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %0b expected 0", busy); end
        checks++; if (src_addr !== 6'd0 || mat_idx !== 2'd0) begin errors++; $display("FAIL stop_clear: got addr %0d idx %0d expected 0 0", src_addr, mat_idx); end
        repeat (5) tick;
        checks++; if (done_q.size() != 0) begin errors++; $display("FAIL stop_no_done: got %0d expected 0", done_q.size()); end
        checks++; if (runs_q.size() != 2 || runs_q[1] != 10) begin errors++; $display("FAIL stop_runs: got %0d runs expected 32 then 10", runs_q.size()); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL stop_word: got none expected %0h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL stop_word: got %0h expected %0h", o, e); end end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL stop_extra: got %0d extra expected 0", obs_q.size()); end
        clear_obs;
        push_words(0, 64);
        run_job(5, 0, 0, 0);
        checks++; if (ah[go_edge + 1] !== 6'd0 || vh[go_edge + 1] !== 1'b1) begin errors++; $display("FAIL stop_restart_addr: got %0d expected 0", ah[go_edge + 1]); end
        checks++; if (done_q.size() != 1) begin errors++; $display("FAIL stop_restart_done: got %0d expected 1", done_q.size()); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL restart_word: got none expected %0h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL restart_word: got %0h expected %0h", o, e); end end
        end
    endtask

    task automatic test_async_reset;
        clear_obs;
        go = 1'b1;
        tick;
        go = 1'b0;
        repeat (6) tick;
        checks++; if (valid_input !== 1'b1 || src_addr !== 6'd5) begin errors++; $display("FAIL arst_setup: got valid %0b addr %0d expected 1 5", valid_input, src_addr); end
        #2 rst = 1'b0;
        #1;
        checks++; if (valid_input !== 1'b0) begin errors++; $display("FAIL arst_valid: got %0b expected 0", valid_input); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %0b expected 0", busy); end
        checks++; if (X_load !== 8'h00) begin errors++; $display("FAIL arst_x_load: got %0h expected 0", X_load); end
        checks++; if (src_addr !== 6'd0) begin errors++; $display("FAIL arst_src_addr: got %0d expected 0", src_addr); end
        checks++; if (start_in !== 1'b0 || done !== 1'b0 || mat_idx !== 2'd0) begin errors++; $display("FAIL arst_misc: got %0b%0b%0d expected 000", start_in, done, mat_idx); end
        #3 rst = 1'b1;
        repeat (5) tick;
        checks++; if (busy !== 1'b0 || start_q.size() != 1) begin errors++; $display("FAIL arst_idle: got busy %0b starts %0d expected 0 1", busy, start_q.size()); end
        clear_obs;
        push_words(0, 64);
        run_job(5, 0, 0, 0);
        checks++; if (done_q.size() != 1) begin errors++; $display("FAIL arst_rerun_done: got %0d expected 1", done_q.size()); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL arst_word: got none expected %0h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL arst_word: got %0h expected %0h", o, e); end end
        end
    endtask

    initial begin
        test_reset;
        test_full_job;
        test_spurious_finish;
        test_go_repulse;
        test_stop;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish within 500000 ns");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/matrix_load_sequencer.md
# matrix_load_sequencer

Synthesizable controller that replaces the bench-side input FSM in front of `top`. It streams NUM_MATRIX matrices of WORDS_PER_MATRIX 8-bit words from an asynchronous-read source memory into `top` using the `start_in` / `valid_input` / `X_load` protocol. After each matrix it waits for `top`'s `finish`, inserts a fixed gap, then issues the next matrix. It sits between the input buffer and `top`, and reports progress to the system controller.

## Interface
- NUM_MATRIX, 2, matrices per job (≥1)
- WORDS_PER_MATRIX, 32, words per matrix (power of two, ≥2)
- GAP_CYCLES, 3, idle cycles between `finish` and the next `start_in` (≥1)
- ADDR_W, clog2(NUM_MATRIX*WORDS_PER_MATRIX), source address width (localparam)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- go  in  1  job request; sampled only in IDLE
- stop  in  1  synchronous abort; highest priority
- src_addr  out  ADDR_W  source memory read address
- src_data  in  8  source word; combinational read of `src_addr`
- start_in  out  1  one-cycle start pulse to `top`
- valid_input  out  1  `X_load` valid
- X_load  out  8  word to `top`; 0 when not valid
- finish  in  1  `top` matrix-complete indication
- mat_idx  out  clog2(NUM_MATRIX)+1  index of the current matrix
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse, job complete

## Operation
- States: IDLE, START, LOAD, WAIT_FIN, GAP, DONE.
- Registers: `state`, `word_cnt` (clog2(WORDS_PER_MATRIX) bits), `mat_idx`, `gap_cnt`.
- All outputs are decoded from registers only. No combinational path from `go`, `finish` or `stop` to any output.

State behaviour:
- IDLE: if `go`=1 → START, `mat_idx`←0.
- START: `start_in`=1. Next state LOAD, `word_cnt`←0.
- LOAD:
  - `valid_input`=1, `X_load`=`src_data`.
  - `src_addr` = `mat_idx`*WORDS_PER_MATRIX + `word_cnt`.
  - `word_cnt` increments each cycle.
  - When `word_cnt`=WORDS_PER_MATRIX-1 → WAIT_FIN.
- WAIT_FIN: on `finish`=1:
  - if `mat_idx`=NUM_MATRIX-1 → DONE;
  - else `mat_idx`++, `gap_cnt`←0, → GAP.
- GAP: `gap_cnt` increments; when `gap_cnt`=GAP_CYCLES-1 → START.
- DONE: `done`=1 for one cycle → IDLE.

Other decoding and reset:
- `src_addr` outside LOAD holds `mat_idx`*WORDS_PER_MATRIX.
- `X_load`=0 and `valid_input`=0 outside LOAD.
- Reset values: state IDLE, all counters 0, `start_in`/`valid_input`/`busy`/`done`=0, `X_load`=0, `src_addr`=0, `mat_idx`=0.

Boundary rules:
- `go` while busy: ignored, not queued.
- `finish` outside WAIT_FIN (including during LOAD or on the cycle of the last LOAD word): ignored.
- `stop`=1 in any state → IDLE at the next edge. Counters are cleared, no `done` pulse, and any LOAD in progress is truncated. `stop` together with `go` in IDLE: stays IDLE.
- `word_cnt` wraps naturally; it is reset on every START.
- Reset asserted mid-job: all state is lost immediately (async); the job must be reissued with `go`.

## Timing
- Edge E0 samples `go`=1 in IDLE. `start_in`=1 during E0→E1.
- First word (`src_addr`=0) is valid during E1→E2. The last word of matrix 0 is valid during E32→E33.
- WAIT_FIN starts at E33. `finish` is sampled on the edge following its assertion.
- `finish` sampled at edge F:
  - non-last matrix: GAP occupies GAP_CYCLES cycles, then `start_in` rises at F+GAP_CYCLES;
  - last matrix: `done` is high during F→F+1 and `busy` falls at F+1.
- Per-matrix latency, `start_in` to WAIT_FIN: 1+WORDS_PER_MATRIX cycles.
- `valid_input` stays contiguous for exactly WORDS_PER_MATRIX cycles per matrix, with no bubbles.

## Test plan
- Reset then `go` pulse, source words 0x00..0x3F, `finish` 5 cycles after each WAIT_FIN entry:
  - `start_in` pulses twice;
  - `X_load` sequence is 0x00..0x1F, then 0x20..0x3F, each in 32 contiguous `valid_input` cycles;
  - `done` is one cycle; `busy` returns to 0.
- Gap check: `finish` sampled at edge F after matrix 0 → second `start_in` high exactly F+3→F+4; `mat_idx`=1 from F+1.
- Spurious `finish` held high throughout LOAD of matrix 0:
  - all 32 words are still delivered;
  - WAIT_FIN exits on the first edge in WAIT_FIN;
  - no word is skipped.
- `go` re-pulsed during LOAD and WAIT_FIN → no extra `start_in`; a single `done` at job end.
- `stop` asserted at the 10th LOAD cycle of matrix 1:
  - `valid_input`=0 and `busy`=0 next cycle; no `done`;
  - a following `go` restarts at `src_addr`=0.
- Async reset asserted mid-LOAD → all outputs reach reset values without a clock edge; FSM stays in IDLE after release until `go`.
